// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   mdState_t : multiply/divide tracker states (IDLE=0, MUL=1, DIV=2)
//   FWD_*     : Execute-stage forward-mux selects
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdState_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/md_tracker.sv
// Multi-cycle multiply/divide occupancy tracker.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   startMul   : multiply issuing from Execute (wins over startDiv)
//   startDiv   : divide issuing from Execute
//   mdBusy     : unit occupied, or being started this cycle
//   mdDone     : one-cycle HI/LO write-enable pulse in the last busy cycle
module md_tracker
  import mips_pkg::*;
#(
  parameter int unsigned MUL_LAT = 32,
  parameter int unsigned DIV_LAT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic startMul,
  input  logic startDiv,
  output logic mdBusy,
  output logic mdDone
);

  mdState_t   state, stateNext;
  logic [7:0] cnt, cntNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // cnt is loaded with LAT-1 and the terminal test is made on the
  // decremented value, so the last busy cycle is LAT-1 cycles after the
  // start cycle and the unit is back in IDLE exactly LAT cycles after it.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mdDone    = 1'b0;
    case (state)
      IDLE: begin
        if (startMul) begin
          stateNext = MUL;
          cntNext   = 8'(MUL_LAT - 1);
        end else if (startDiv) begin
          stateNext = DIV;
          cntNext   = 8'(DIV_LAT - 1);
        end
      end
      MUL, DIV: begin
        cntNext = cnt - 8'd1;
        if (cntNext == '0) begin
          // An aborting reset must not commit HI/LO.
          mdDone    = ~reset;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  assign mdBusy = (state != IDLE) | startMul | startDiv;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use, branch-compare and multiply/divide stalls,
// Decode and Execute operand forwarding.
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   branchD, mdstartD, hiloreadD : Decode-stage instruction class
//   memtoregE/M, regwriteE/M/W : pipeline control per stage
//   start_mulE, start_divE     : mult/div issuing from Execute
//   rsD, rtD, rsE, rtE         : source register indices
//   writeregE/M/W              : destination register indices
//   stallF, stallD, flushE     : pipeline hold / bubble insertion
//   forwardaD, forwardbD       : Decode operands taken from Memory
//   forwardaE, forwardbE       : Execute operand select (FWD_RF/FWD_WB/FWD_MEM)
//   md_busy, md_done           : multi-cycle unit occupancy and HI/LO write pulse
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned MUL_LAT = 32,
  parameter int unsigned DIV_LAT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branchD,
  input  logic             mdstartD,
  input  logic             hiloreadD,
  input  logic             memtoregE,
  input  logic             regwriteE,
  input  logic             memtoregM,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             start_mulE,
  input  logic             start_divE,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             md_busy,
  output logic             md_done
);

  logic lwStall, branchStall, mdStall;
  logic exeHitD, memHitD;

  md_tracker #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) uTracker (
    .clk      (clk),
    .reset    (reset),
    .startMul (start_mulE),
    .startDiv (start_divE),
    .mdBusy   (md_busy),
    .mdDone   (md_done)
  );

  // Memory-stage value wins over Writeback; register 0 is never forwarded.
  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src,
                                        input logic [REG_W-1:0] wrM,
                                        input logic             wenM,
                                        input logic [REG_W-1:0] wrW,
                                        input logic             wenW);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (wenM && src == wrM)      sel = FWD_MEM;
      else if (wenW && src == wrW) sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    lwStall = memtoregE & (rtE != '0) & ((rsD == rtE) | (rtD == rtE));

    exeHitD = regwriteE & (writeregE != '0) &
              ((writeregE == rsD) | (writeregE == rtD));
    memHitD = memtoregM & (writeregM != '0) &
              ((writeregM == rsD) | (writeregM == rtD));
    branchStall = branchD & (exeHitD | memHitD);

    mdStall = md_busy & (hiloreadD | mdstartD);

    flushE = lwStall | branchStall | mdStall;
    stallD = flushE;
    stallF = flushE;

    forwardaD = (rsD != '0) & (rsD == writeregM) & regwriteM;
    forwardbD = (rtD != '0) & (rtD == writeregM) & regwriteM;

    forwardaE = fwdSel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardbE = fwdSel(rtE, writeregM, regwriteM, writeregW, regwriteW);
  end

endmodule
